mult_sequencer: RTL and testbench

- Control FSM for the shift-add multiplier datapath in the arithmetic processor. The datapath holds the A, Q and M registers and a carry bit C.
- Accepts a START/DONE handshake from ControlUnit during MUL-class instructions.
- Drives the load, add, shift and clear strobes for the datapath, one bit per iteration.
- Owns the iteration counter that ControlUnit currently hand-rolls in its Count register.

---
 rtl/mult_seq_pkg.sv | 7 +
 rtl/mult_iter_counter.sv | 18 +
 rtl/mult_sequencer.sv | 67 ++++++
 tb/tb_mult_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared state encoding, default width and Booth decode constants for mult_sequencer.
package mult_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, EVAL, SHIFT, DONE} state_t;
  localparam int WIDTH_DEF = 8;
  localparam logic [1:0] BOOTH_SUB = 2'b10;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
endpackage

// File: rtl/mult_iter_counter.sv
// mult_iter_counter: iteration counter with clear, increment and terminal count at WIDTH-1.
module mult_iter_counter import mult_seq_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  assign tc = cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: control FSM for the shift-add multiplier datapath.
// Define MULT_SEQ_BOOTH_EN for signed radix-2 Booth operation (adds q_m1, sub, asr).
module mult_sequencer import mult_seq_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic start,
  input  logic q0,
`ifdef MULT_SEQ_BOOTH_EN
  input  logic q_m1,
  output logic sub,
  output logic asr,
`endif
  output logic ldm,
  output logic ldq,
  output logic clr_a,
  output logic lda,
  output logic sr,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, nxt;
  logic ld, eval, tc;
  mult_iter_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr || state == LOAD),
    .inc(state == SHIFT),
    .tc(tc)
  );
  always_comb
    nxt = clr ? IDLE :
          state == IDLE  ? (start ? LOAD : IDLE) :
          state == LOAD  ? EVAL :
          state == EVAL  ? SHIFT :
          state == SHIFT ? (tc ? DONE : EVAL) : IDLE;
  // outputs are registered from the next state so they line up with the state they decode
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ld    <= 1'b0;
      eval  <= 1'b0;
      sr    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      ld    <= nxt == LOAD;
      eval  <= nxt == EVAL;
      sr    <= nxt == SHIFT;
      busy  <= nxt == LOAD || nxt == EVAL || nxt == SHIFT;
      done  <= nxt == DONE;
    end
  assign ldm   = ld;
  assign ldq   = ld;
  assign clr_a = ld;
`ifdef MULT_SEQ_BOOTH_EN
  assign lda = eval && ({q0, q_m1} == BOOTH_SUB || {q0, q_m1} == BOOTH_ADD);
  assign sub = eval && {q0, q_m1} == BOOTH_SUB;
  assign asr = sr;
`else
  assign lda = eval && q0;
`endif
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed and random multiplies through a bench datapath, checked against arithmetic expectations.
module tb_mult_sequencer;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, start = 1'b0, q0;
  logic ldm, ldq, clr_a, lda, sr, busy, done;
  logic [W-1:0] m_bus = '0, q_bus = '0, m_r, q_r, a_r;
  logic c_r;
  int checks = 0, errors = 0;
`ifdef MULT_SEQ_BOOTH_EN
  logic q_m1, sub, asr, qm1_r;
  assign q_m1 = qm1_r;
`endif
  always #5 clk = ~clk;
  assign q0 = q_r[0];

  mult_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .q0(q0),
`ifdef MULT_SEQ_BOOTH_EN
    .q_m1(q_m1), .sub(sub), .asr(asr),
`endif
    .ldm(ldm), .ldq(ldq), .clr_a(clr_a), .lda(lda), .sr(sr), .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (ldm) m_r <= m_bus;
    if (ldq) q_r <= q_bus;
`ifdef MULT_SEQ_BOOTH_EN
    if (clr_a) begin {c_r, a_r} <= '0; qm1_r <= 1'b0; end
    if (lda) {c_r, a_r} <= sub ? {c_r, a_r} - {m_r[W-1], m_r} : {c_r, a_r} + {m_r[W-1], m_r};
    if (sr && asr) begin {c_r, a_r, q_r} <= {c_r, c_r, a_r, q_r[W-1:1]}; qm1_r <= q_r[0]; end
`else
    if (clr_a) {c_r, a_r} <= '0;
    if (lda) {c_r, a_r} <= {1'b0, a_r} + {1'b0, m_r};
    if (sr) {c_r, a_r, q_r} <= {1'b0, c_r, a_r, q_r[W-1:1]};
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] lda_exp(input logic [W-1:0] q);
    logic [W-1:0] prev = {q[W-2:0], 1'b0};
`ifdef MULT_SEQ_BOOTH_EN
    return q ^ prev;
`else
    return q;
`endif
  endfunction

  function automatic logic [W-1:0] sub_exp(input logic [W-1:0] q);
`ifdef MULT_SEQ_BOOTH_EN
    logic [W-1:0] prev = {q[W-2:0], 1'b0};
    return q & ~prev;
`else
    return '0;
`endif
  endfunction

  function automatic logic [2*W-1:0] prod_exp(input logic [W-1:0] m, input logic [W-1:0] q);
    int p;
`ifdef MULT_SEQ_BOOTH_EN
    p = $signed(m) * $signed(q);
`else
    p = int'(m) * int'(q);
`endif
    return (2*W)'(p);
  endfunction

  // one multiply from IDLE; an optional START pulse at cycle pulse_c must be ignored
  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, input int pulse_c);
    int dc = 0, nsr = 0, ov = 0, bb = 0;
    logic [W-1:0] lm = '0, sm = '0;
    m_bus = m;
    q_bus = q;
    start = 1'b1;
    for (int c = 1; c <= 60 && dc == 0; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (pulse_c != 0 && c == pulse_c) start = 1'b1;
      if (pulse_c != 0 && c == pulse_c + 1) start = 1'b0;
      if (lda) lm[(c - 2) / 2] = 1'b1;
`ifdef MULT_SEQ_BOOTH_EN
      if (lda && sub) sm[(c - 2) / 2] = 1'b1;
      if (sub && !lda) ov++;
      if (sr !== asr) ov++;
`endif
      if (sr) nsr++;
      if (lda && sr) ov++;
      if (busy !== (c <= 2 * W + 1)) bb++;
      if (done) dc = c;
    end
    chk("done_cycle", dc, 2 * W + 2);
    chk("lda_iters", lm, lda_exp(q));
    chk("sub_iters", sm, sub_exp(q));
    chk("sr_count", nsr, W);
    chk("overlap", ov, 0);
    chk("busy_profile", bb, 0);
    chk("product", {a_r, q_r}, prod_exp(m, q));
    @(negedge clk);
  endtask

  task automatic no_done_for(input int n, input string tag);
    int nd = 0, nb = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    chk(tag, nd, 0);
    chk({tag, "_busy"}, nb, 0);
  endtask

  initial begin
    int t[3] = '{0, 0, 0};
    int k = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {ldm, ldq, clr_a, lda, sr, busy, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", {ldm, ldq, clr_a, lda, sr, busy, done}, 0);

    do_op(8'd13, 8'd11, 0);
    do_op(8'd13, 8'd0, 0);
    do_op(8'd255, 8'd255, 0);
`ifdef MULT_SEQ_BOOTH_EN
    do_op(8'hFD, 8'd7, 0);
`endif
    for (int i = 0; i < 8; i++)
      do_op(W'($urandom), W'($urandom), (i % 2 == 1) ? 5 + 2 * i : 0);

    m_bus = W'($urandom);
    q_bus = W'($urandom);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 5) clr = 1'b1;
    end
    @(negedge clk);
    clr = 1'b0;
    chk("clr_idle", {busy, done, sr, lda}, 0);
    no_done_for(40, "clr_no_done");
    do_op(8'd3, 8'd5, 0);

    m_bus = 8'd9;
    q_bus = 8'd6;
    start = 1'b1;
    for (int c = 1; c <= 80 && k < 3; c++) begin
      @(negedge clk);
      if (done) begin t[k] = c; k++; end
    end
    start = 1'b0;
    chk("held_first", t[0], 2 * W + 2);
    chk("held_period1", t[1] - t[0], 2 * W + 3);
    chk("held_period2", t[2] - t[1], 2 * W + 3);
    chk("held_product", {a_r, q_r}, prod_exp(8'd9, 8'd6));
    @(negedge clk);

    m_bus = 8'd7;
    q_bus = 8'hFF;
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {ldm, ldq, clr_a, lda, sr, busy, done}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    no_done_for(40, "reset_no_done");
    do_op(8'd13, 8'd11, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
